// File: rtl/vga_frame_reader.sv
// VGA raster timing plus framebuffer scan-out for the Julia-set renderer.
// Intensity is read in raster order, clamped, mapped to grayscale and kept aligned with sync/blank.
module vga_frame_reader #(
   parameter int H_ACTIVE      = 640,
   parameter int H_FP          = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BP          = 48,
   parameter int V_ACTIVE      = 480,
   parameter int V_FP          = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BP          = 33,
   parameter int RD_LATENCY    = 2,
   parameter int MAX_INTENSITY = 100,
   parameter int ADDR_W        = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   output logic              fb_rd_en,
   output logic [ADDR_W-1:0] fb_rd_addr,
   input  logic [7:0]        fb_rd_data,
   input  logic              calc_done,
   output logic              frame_start,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank_n
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W     = $clog2(H_TOTAL);
   localparam int VC_W     = $clog2(V_TOTAL);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   // gray = min(raw, MAX) * 163 / 64 spreads 0..100 across 0..254
   function automatic logic [7:0] gray_map(input logic [7:0] raw);
      logic [7:0] clamped;
      clamped = (raw > 8'(MAX_INTENSITY)) ? 8'(MAX_INTENSITY) : raw;
      return 8'((16'(clamped) * 16'd163) >> 6);
   endfunction

   logic [HC_W-1:0]       h_cnt_r;
   logic [VC_W-1:0]       v_cnt_r;
   logic [ADDR_W-1:0]     fb_rd_addr_r;
   logic                  frame_valid_r;
   logic [RD_LATENCY-1:0] act_pipe_r;
   logic [RD_LATENCY-1:0] hs_pipe_r;
   logic [RD_LATENCY-1:0] vs_pipe_r;
   logic [7:0]            gray_r;
   logic                  vga_hs_r;
   logic                  vga_vs_r;
   logic                  vga_blank_n_r;
   logic                  frame_start_r;

   logic h_last_s;
   logic v_last_s;
   logic active_s;
   logic hs_raw_s;
   logic vs_raw_s;
   logic fs_set_s;

   // Decode the current raster position into raw timing signals
   always_comb begin
      h_last_s = (h_cnt_r == HC_W'(H_TOTAL - 1));
      v_last_s = (v_cnt_r == VC_W'(V_TOTAL - 1));
      active_s = (h_cnt_r < HC_W'(H_ACTIVE)) && (v_cnt_r < VC_W'(V_ACTIVE));
      hs_raw_s = (h_cnt_r >= HC_W'(HS_START)) && (h_cnt_r <= HC_W'(HS_END));
      vs_raw_s = (v_cnt_r >= VC_W'(VS_START)) && (v_cnt_r <= VC_W'(VS_END));
      fs_set_s = pix_en && h_last_s && (v_cnt_r == VC_W'(V_ACTIVE - 1));
   end

   // Raster counters, incremental read address and per-frame display enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt_r       <= '0;
         v_cnt_r       <= '0;
         fb_rd_addr_r  <= '0;
         frame_valid_r <= 1'b0;
      end else if (pix_en) begin
         if (h_last_s) begin
            h_cnt_r <= '0;
            v_cnt_r <= v_last_s ? '0 : v_cnt_r + VC_W'(1);
         end else begin
            h_cnt_r <= h_cnt_r + HC_W'(1);
         end
         if (h_last_s && v_last_s) begin
            fb_rd_addr_r <= '0;
         end else if (active_s) begin
            fb_rd_addr_r <= fb_rd_addr_r + ADDR_W'(1);
         end
         // Latched only at (0,0) so a frame is never torn by a late calc_done
         if ((h_cnt_r == '0) && (v_cnt_r == '0)) begin
            frame_valid_r <= calc_done;
         end
      end
   end

   // Control delay line matching the framebuffer read latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_pipe_r <= '0;
         hs_pipe_r  <= '0;
         vs_pipe_r  <= '0;
      end else if (pix_en) begin
         act_pipe_r[0] <= active_s;
         hs_pipe_r[0]  <= hs_raw_s;
         vs_pipe_r[0]  <= vs_raw_s;
         for (int i = 1; i < RD_LATENCY; i++) begin
            act_pipe_r[i] <= act_pipe_r[i-1];
            hs_pipe_r[i]  <= hs_pipe_r[i-1];
            vs_pipe_r[i]  <= vs_pipe_r[i-1];
         end
      end
   end

   // Pin stage: colour is sampled together with the delayed controls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gray_r        <= 8'd0;
         vga_hs_r      <= 1'b1;
         vga_vs_r      <= 1'b1;
         vga_blank_n_r <= 1'b0;
      end else if (pix_en) begin
         vga_hs_r      <= ~hs_pipe_r[RD_LATENCY-1];
         vga_vs_r      <= ~vs_pipe_r[RD_LATENCY-1];
         vga_blank_n_r <= act_pipe_r[RD_LATENCY-1];
         gray_r        <= (act_pipe_r[RD_LATENCY-1] && frame_valid_r) ? gray_map(fb_rd_data) : 8'd0;
      end
   end

   // One-clk start-of-vblank pulse, not delayed by the read pipeline
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= fs_set_s;
      end
   end

   assign fb_rd_en    = pix_en;
   assign fb_rd_addr  = fb_rd_addr_r;
   assign frame_start = frame_start_r;
   assign vga_r       = gray_r;
   assign vga_g       = gray_r;
   assign vga_b       = gray_r;
   assign vga_hs      = vga_hs_r;
   assign vga_vs      = vga_vs_r;
   assign vga_blank_n = vga_blank_n_r;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a reduced 32x8 raster (48x15 total, 720 strobes/frame).
// The framebuffer model returns addr[7:0] after two strobes.
module tb_vga_frame_reader;

   localparam int LAT   = 2;
   localparam int AW    = 19;
   localparam int HA    = 32;
   localparam int VA    = 8;
   localparam int HT    = 48;
   localparam int FRAME = 720;

   logic          clk = 1'b0;
   logic          reset;
   logic          pix_en;
   logic          calc_done;
   logic          fb_rd_en;
   logic [AW-1:0] fb_rd_addr;
   logic [7:0]    fb_rd_data;
   logic          frame_start;
   logic [7:0]    vga_r, vga_g, vga_b;
   logic          vga_hs, vga_vs, vga_blank_n;

   logic [7:0] ram_pipe [LAT];
   int         passed = 0;
   int         total  = 0;
   int         strobes = 0;
   logic       fs_at_strobe;
   int         fs_in_gap;
   int         fv [64];

   always #5 clk = ~clk;

   vga_frame_reader #(
      .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .RD_LATENCY(LAT), .MAX_INTENSITY(100), .ADDR_W(AW)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .fb_rd_en(fb_rd_en),
      .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data), .calc_done(calc_done),
      .frame_start(frame_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
   );

   // Framebuffer model: data = addr[7:0], visible LAT strobes after the address
   always @(posedge clk) begin
      if (fb_rd_en) begin
         ram_pipe[0] <= fb_rd_addr[7:0];
         for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
      end
   end
   assign fb_rd_data = ram_pipe[LAT-1];

   function automatic logic [26:0] act_pins();
      return {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
   endfunction

   // Expected pins after m strobes since reset: they show raster position m-LAT-1
   function automatic logic [26:0] exp_pins(input int m);
      int q, f, p, h, v, c;
      logic hs, vs, act;
      logic [7:0] g;
      if (m < LAT + 1) return {1'b1, 1'b1, 1'b0, 24'd0};
      q = m - LAT - 1;
      f = q / FRAME;
      p = q % FRAME;
      h = p % HT;
      v = p / HT;
      hs  = !(h >= 36 && h <= 43);
      vs  = !(v == 10 || v == 11);
      act = (h < HA) && (v < VA);
      c = (v * HA + h) % 256;
      if (c > 100) c = 100;
      g = (act && fv[f] != 0) ? 8'((c * 163) / 64) : 8'd0;
      return {hs, vs, act, g, g, g};
   endfunction

   // Expected read address when the counters sit at position m of the frame
   function automatic int exp_addr(input int m);
      int p, h, v;
      p = m % FRAME;
      h = p % HT;
      v = p / HT;
      if (v >= VA) return 256;
      return v * HA + ((h < HA) ? h : HA);
   endfunction

   task automatic do_reset(input logic cd);
      reset = 1'b1;
      pix_en = 1'b0;
      calc_done = cd;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      strobes = 0;
   endtask

   // One pix_en strobe followed by gap idle clocks; ends on a negedge
   task automatic step(input int gap);
      if ((strobes % FRAME) == 0 && (strobes / FRAME) < 64) fv[strobes / FRAME] = calc_done;
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      strobes++;
      fs_at_strobe = frame_start;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         if (frame_start) fs_in_gap++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; pix_en = 1'b0; calc_done = 1'b1;
      repeat (4) @(negedge clk);
      pix_en = 1'b1;
      #1;
      total++; if (fb_rd_en !== 1'b1) $display("FAIL reset_rd_en_hi: got %b required 1", fb_rd_en); else passed++;
      @(negedge clk);
      pix_en = 1'b0;
      #1;
      total++; if (fb_rd_en !== 1'b0) $display("FAIL reset_rd_en_lo: got %b required 0", fb_rd_en); else passed++;
      total++; if (act_pins() !== {1'b1, 1'b1, 1'b0, 24'd0}) $display("FAIL reset_pins: got %h required %h", act_pins(), {1'b1, 1'b1, 1'b0, 24'd0}); else passed++;
      total++; if (fb_rd_addr !== '0) $display("FAIL reset_addr: got %0d required 0", fb_rd_addr); else passed++;
      total++; if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b required 0", frame_start); else passed++;
      reset = 1'b0;
      strobes = 0;
   endtask

   task automatic test_timing;
      int e_pin = 0, e_addr = 0, e_fs = 0, n_hs = 0, n_vs = 0, n_bl = 0, first_hs = -1;
      do_reset(1'b1);
      fs_in_gap = 0;
      for (int k = 0; k < 2 * FRAME + LAT; k++) begin
         step(3);
         if (act_pins() !== exp_pins(strobes)) e_pin++;
         if (fb_rd_addr !== AW'(exp_addr(strobes))) e_addr++;
         if (fs_at_strobe !== ((strobes % FRAME) == 384)) e_fs++;
         if (strobes > LAT) begin
            n_hs += int'(!vga_hs);
            n_vs += int'(!vga_vs);
            n_bl += int'(vga_blank_n);
         end
         if (first_hs < 0 && !vga_hs) first_hs = strobes;
      end
      total++; if (e_pin != 0) $display("FAIL timing_pins: %0d bad strobes, required 0", e_pin); else passed++;
      total++; if (e_addr != 0) $display("FAIL timing_addr: %0d bad strobes, required 0", e_addr); else passed++;
      total++; if (e_fs != 0) $display("FAIL timing_fs: %0d bad strobes, required 0", e_fs); else passed++;
      total++; if (fs_in_gap != 0) $display("FAIL timing_fs_width: %0d extra clks, required 0", fs_in_gap); else passed++;
      total++; if (n_hs != 240) $display("FAIL timing_hs_count: got %0d required 240", n_hs); else passed++;
      total++; if (n_vs != 192) $display("FAIL timing_vs_count: got %0d required 192", n_vs); else passed++;
      total++; if (n_bl != 512) $display("FAIL timing_blank_count: got %0d required 512", n_bl); else passed++;
      total++; if (first_hs != 39) $display("FAIL timing_hs_edge: got %0d required 39", first_hs); else passed++;
   endtask

   task automatic test_gray;
      int         q_tab [7] = '{0, 3, 40, 66, 148, 296, 367};
      logic [7:0] g_tab [7] = '{8'd0, 8'd7, 8'd0, 8'd127, 8'd254, 8'd254, 8'd254};
      int         a_pos [4] = '{367, 368, 719, 720};
      int         a_val [4] = '{255, 256, 256, 0};
      do_reset(1'b1);
      for (int i = 0; i < 4; i++) begin
         while (strobes < a_pos[i]) step(0);
         total++;
         if (fb_rd_addr !== AW'(a_val[i])) $display("FAIL addr_at_%0d: got %0d required %0d", a_pos[i], fb_rd_addr, a_val[i]);
         else passed++;
      end
      do_reset(1'b1);
      for (int i = 0; i < 7; i++) begin
         while (strobes < q_tab[i] + LAT + 1) step(0);
         total++;
         if ({vga_r, vga_g, vga_b} !== {3{g_tab[i]}})
            $display("FAIL gray_pos_%0d: got %h/%h/%h required %h", q_tab[i], vga_r, vga_g, vga_b, g_tab[i]);
         else passed++;
      end
   endtask

   task automatic test_calc_gate;
      int nz0 = 0, nz1 = 0, e_pin = 0, n_hs = 0;
      do_reset(1'b0);
      for (int k = 0; k < 2 * FRAME + LAT; k++) begin
         if (strobes == 96) calc_done = 1'b1;
         step(0);
         if (act_pins() !== exp_pins(strobes)) e_pin++;
         if (strobes > LAT) begin
            if (strobes <= FRAME + LAT) nz0 += int'(vga_r != 8'd0);
            else nz1 += int'(vga_r != 8'd0);
            n_hs += int'(!vga_hs);
         end
      end
      total++; if (nz0 != 0) $display("FAIL gate_frame0_lit: got %0d required 0", nz0); else passed++;
      total++; if (nz1 != 255) $display("FAIL gate_frame1_lit: got %0d required 255", nz1); else passed++;
      total++; if (n_hs != 240) $display("FAIL gate_hs_count: got %0d required 240", n_hs); else passed++;
      total++; if (e_pin != 0) $display("FAIL gate_pins: %0d bad strobes, required 0", e_pin); else passed++;
   endtask

   task automatic test_frame_start;
      int cnt = 0;
      int at [3] = '{0, 0, 0};
      do_reset(1'b1);
      for (int k = 0; k < 3 * FRAME; k++) begin
         step(0);
         if (fs_at_strobe) begin
            if (cnt < 3) at[cnt] = strobes;
            cnt++;
         end
      end
      total++; if (cnt != 3) $display("FAIL fs_count: got %0d required 3", cnt); else passed++;
      total++; if (at[0] != 384) $display("FAIL fs_first: got %0d required 384", at[0]); else passed++;
      total++; if (at[1] - at[0] != FRAME) $display("FAIL fs_space1: got %0d required 720", at[1] - at[0]); else passed++;
      total++; if (at[2] - at[1] != FRAME) $display("FAIL fs_space2: got %0d required 720", at[2] - at[1]); else passed++;
   endtask

   task automatic test_mid_reset;
      int e_pin = 0, e_addr = 0;
      do_reset(1'b1);
      while (strobes < 260) step(1);
      total++; if ({vga_blank_n, vga_r} !== {1'b1, 8'd254}) $display("FAIL mrst_pre: got %b/%0d required 1/254", vga_blank_n, vga_r); else passed++;
      reset = 1'b1;
      #1;
      total++; if (act_pins() !== {1'b1, 1'b1, 1'b0, 24'd0}) $display("FAIL mrst_pins: got %h required %h", act_pins(), {1'b1, 1'b1, 1'b0, 24'd0}); else passed++;
      total++; if (fb_rd_addr !== '0) $display("FAIL mrst_addr: got %0d required 0", fb_rd_addr); else passed++;
      pix_en = 1'b1;
      repeat (3) @(negedge clk);
      pix_en = 1'b0;
      total++; if (act_pins() !== {1'b1, 1'b1, 1'b0, 24'd0}) $display("FAIL mrst_hold: got %h required %h", act_pins(), {1'b1, 1'b1, 1'b0, 24'd0}); else passed++;
      reset = 1'b0;
      strobes = 0;
      total++; if (fb_rd_addr !== '0) $display("FAIL mrst_first_addr: got %0d required 0", fb_rd_addr); else passed++;
      for (int k = 0; k < 400; k++) begin
         step(1);
         if (act_pins() !== exp_pins(strobes)) e_pin++;
         if (fb_rd_addr !== AW'(exp_addr(strobes))) e_addr++;
      end
      total++; if (e_pin != 0) $display("FAIL mrst_pins_after: %0d bad strobes, required 0", e_pin); else passed++;
      total++; if (e_addr != 0) $display("FAIL mrst_addr_after: %0d bad strobes, required 0", e_addr); else passed++;
   endtask

   task automatic test_stall;
      int changes = 0, e_pin = 0, e_addr = 0;
      logic [26:0]   snap;
      logic [AW-1:0] snap_addr;
      do_reset(1'b1);
      while (strobes < 100) step(0);
      snap = act_pins();
      snap_addr = fb_rd_addr;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (act_pins() !== snap || fb_rd_addr !== snap_addr || frame_start !== 1'b0) changes++;
      end
      total++; if (changes != 0) $display("FAIL stall_frozen: %0d changed clks, required 0", changes); else passed++;
      total++; if (snap !== exp_pins(100)) $display("FAIL stall_snap: got %h required %h", snap, exp_pins(100)); else passed++;
      total++; if (snap_addr !== AW'(exp_addr(100))) $display("FAIL stall_addr: got %0d required %0d", snap_addr, exp_addr(100)); else passed++;
      for (int k = 0; k < 200; k++) begin
         step(0);
         if (act_pins() !== exp_pins(strobes)) e_pin++;
         if (fb_rd_addr !== AW'(exp_addr(strobes))) e_addr++;
      end
      total++; if (e_pin != 0) $display("FAIL stall_resume_pins: %0d bad strobes, required 0", e_pin); else passed++;
      total++; if (e_addr != 0) $display("FAIL stall_resume_addr: %0d bad strobes, required 0", e_addr); else passed++;
   endtask

   initial begin
      reset = 1'b1;
      pix_en = 1'b0;
      calc_done = 1'b0;
      for (int i = 0; i < 64; i++) fv[i] = 0;
      test_reset;
      test_timing;
      test_gray;
      test_calc_gate;
      test_frame_start;
      test_mid_reset;
      test_stall;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
